// File: rtl/muldiv_iter_pkg.sv
// Shared types for the iterative multiply/divide unit: op codes, FSM states and op decode.
// MULDIV_ACC_EN selects whether madd/msub ops keep their accumulate meaning.
package muldiv_iter_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } muldiv_st_e;

  function automatic logic op_is_div(muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic op_is_signed(muldiv_op_e op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

  // Without the accumulator the madd/msub family collapses onto plain multiplies.
  function automatic muldiv_op_e op_decode(muldiv_op_e op);
`ifdef MULDIV_ACC_EN
    return op;
`else
    case (op)
      OP_MADD, OP_MSUB:   return OP_MULT;
      OP_MADDU, OP_MSUBU: return OP_MULTU;
      default:            return op;
    endcase
`endif
  endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// EX-stage request/response bundle for the multiply/divide unit.
interface muldiv_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic                               start_i;
  logic                               annul_i;
  logic [muldiv_iter_pkg::OP_W-1:0]   op_i;
  logic [WIDTH-1:0]                   op1_i;
  logic [WIDTH-1:0]                   op2_i;
  logic [2*WIDTH-1:0]                 hilo_i;
  logic [2*WIDTH-1:0]                 result_o;
  logic                               ready_o;
  logic                               busy_o;
  logic                               div0_o;

  modport master (
    output start_i, annul_i, op_i, op1_i, op2_i, hilo_i,
    input  result_o, ready_o, busy_o, div0_o
  );

  modport slave (
    input  start_i, annul_i, op_i, op1_i, op2_i, hilo_i,
    output result_o, ready_o, busy_o, div0_o
  );
endinterface

// File: rtl/muldiv_iter_step.sv
// One radix-2 step: shift-add multiply or restoring divide on a {hi,lo} partial pair.
module muldiv_iter_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] opnd,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi_c,
  output logic [WIDTH-1:0] lo_c
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    rem_sh = {hi, lo[WIDTH-1]};
    ge     = rem_sh >= {1'b0, opnd};
    // When ge holds the true difference is below the divisor, so WIDTH bits suffice.
    diff   = rem_sh[WIDTH-1:0] - opnd;
    if (is_div) begin
      hi_c = ge ? diff : rem_sh[WIDTH-1:0];
      lo_c = {lo[WIDTH-2:0], ge};
    end else begin
      hi_c = sum[WIDTH:1];
      lo_c = {sum[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit for HI/LO ops, UNROLL steps per cycle, result as {hi,lo}.
// Define MULDIV_ACC_EN to build the madd/msub accumulator.
module muldiv_iter
  import muldiv_iter_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned UNROLL = 1
) (
  input logic          clk,
  input logic          rst,
  muldiv_iter_if.slave bus
);

  localparam int unsigned N     = WIDTH / UNROLL;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RES_W = 2 * WIDTH;

  muldiv_st_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  muldiv_op_e        op_q;
  logic [WIDTH-1:0]  opnd_q, hi_q, lo_q, op1_q;
  logic              neg_lo_q, neg_hi_q, zero_q;
`ifdef MULDIV_ACC_EN
  logic [RES_W-1:0]  hilo_q;
`endif

  logic [RES_W-1:0]  result_q, result_nxt;
  logic              ready_q, ready_nxt, busy_q, busy_nxt, div0_q, div0_nxt;

  // Request decode and operand magnitudes
  muldiv_op_e        op_in;
  logic              in_div, in_signed, a_neg, b_neg, in_zero, start_ok;
  logic [WIDTH-1:0]  a_mag, b_mag;

  assign op_in     = op_decode(muldiv_op_e'(bus.op_i));
  assign in_div    = op_is_div(op_in);
  assign in_signed = op_is_signed(op_in);
  assign a_neg     = in_signed & bus.op1_i[WIDTH-1];
  assign b_neg     = in_signed & bus.op2_i[WIDTH-1];
  assign a_mag     = a_neg ? -bus.op1_i : bus.op1_i;
  assign b_mag     = b_neg ? -bus.op2_i : bus.op2_i;
  assign in_zero   = in_div && (bus.op2_i == '0);
  assign start_ok  = bus.start_i && !bus.annul_i;

  // Unrolled step chain
  logic             q_is_div;
  logic [WIDTH-1:0] chain_hi [UNROLL+1];
  logic [WIDTH-1:0] chain_lo [UNROLL+1];

  assign q_is_div    = op_is_div(op_q);
  assign chain_hi[0] = hi_q;
  assign chain_lo[0] = lo_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
      .is_div (q_is_div),
      .opnd   (opnd_q),
      .hi     (chain_hi[g]),
      .lo     (chain_lo[g]),
      .hi_c   (chain_hi[g+1]),
      .lo_c   (chain_lo[g+1])
    );
  end

  // Sign correction and optional accumulate
  logic [RES_W-1:0] prod_s, acc_res, fix_res;
  logic [WIDTH-1:0] quo_s, rem_s;

  always_comb begin
    prod_s = neg_lo_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_s  = neg_lo_q ? -lo_q : lo_q;
    rem_s  = neg_hi_q ? -hi_q : hi_q;
    acc_res = prod_s;
`ifdef MULDIV_ACC_EN
    if (op_q inside {OP_MADD, OP_MADDU}) acc_res = hilo_q + prod_s;
    else if (op_q inside {OP_MSUB, OP_MSUBU}) acc_res = hilo_q - prod_s;
`endif
    if (zero_q)        fix_res = {op1_q, {WIDTH{1'b1}}};
    else if (q_is_div) fix_res = {rem_s, quo_s};
    else               fix_res = acc_res;
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      result_q <= result_nxt;
      ready_q  <= ready_nxt;
      busy_q   <= busy_nxt;
      div0_q   <= div0_nxt;
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    if (bus.annul_i) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (bus.start_i) state_nxt = in_zero ? ST_FIXUP : ST_CALC;
        ST_CALC:  if (cnt == CNT_W'(N - 1)) state_nxt = ST_FIXUP;
        ST_FIXUP: state_nxt = ST_DONE;
        ST_DONE:  if (!bus.start_i) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Next output values; result only changes on a completed fixup
  always_comb begin
    result_nxt = result_q;
    ready_nxt  = 1'b0;
    busy_nxt   = 1'b0;
    div0_nxt   = 1'b0;
    if (state == ST_FIXUP && state_nxt == ST_DONE) result_nxt = fix_res;
    ready_nxt = (state_nxt == ST_DONE);
    busy_nxt  = (state_nxt == ST_CALC) || (state_nxt == ST_FIXUP);
    div0_nxt  = (state_nxt == ST_DONE) && zero_q;
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      op_q     <= OP_MULT;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      op1_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      zero_q   <= 1'b0;
`ifdef MULDIV_ACC_EN
      hilo_q   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (start_ok) begin
          cnt      <= '0;
          op_q     <= op_in;
          opnd_q   <= in_div ? b_mag : a_mag;
          hi_q     <= '0;
          lo_q     <= in_div ? a_mag : b_mag;
          op1_q    <= bus.op1_i;
          neg_lo_q <= a_neg ^ b_neg;
          neg_hi_q <= in_div & a_neg;
          zero_q   <= in_zero;
`ifdef MULDIV_ACC_EN
          hilo_q   <= bus.hilo_i;
`endif
        end
        ST_CALC: begin
          hi_q <= chain_hi[UNROLL];
          lo_q <= chain_lo[UNROLL];
          cnt  <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.busy_o   = busy_q;
  assign bus.div0_o   = div0_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: UNROLL=1 and UNROLL=4 instances driven in lockstep against a behavioural model.
module tb_muldiv_iter;
  import muldiv_iter_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start, annul;
  logic [2:0]        op;
  logic [W-1:0]      op1, op2;
  logic [2*W-1:0]    hilo;

  muldiv_iter_if #(.WIDTH(W)) bus1 ();
  muldiv_iter_if #(.WIDTH(W)) bus4 ();

  assign bus1.start_i = start;  assign bus4.start_i = start;
  assign bus1.annul_i = annul;  assign bus4.annul_i = annul;
  assign bus1.op_i    = op;     assign bus4.op_i    = op;
  assign bus1.op1_i   = op1;    assign bus4.op1_i   = op1;
  assign bus1.op2_i   = op2;    assign bus4.op2_i   = op2;
  assign bus1.hilo_i  = hilo;   assign bus4.hilo_i  = hilo;

  muldiv_iter #(.WIDTH(W), .UNROLL(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  muldiv_iter #(.WIDTH(W), .UNROLL(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Architectural result of one op, straight from the arithmetic definition
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] h);
    longint sa, sb;
    logic [63:0] p;
    logic [31:0] q, r;
    logic sgn;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sgn = !o[0];
    if (o == 3'd2 || o == 3'd3) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (sgn) begin
        q = 32'(sa / sb);
        r = 32'(sa % sb);
      end else begin
        q = a / b;
        r = a % b;
      end
      return {r, q};
    end
    p = sgn ? 64'(sa * sb) : ({32'd0, a} * {32'd0, b});
`ifdef MULDIV_ACC_EN
    if (o == 3'd4 || o == 3'd5) return h + p;
    if (o == 3'd6 || o == 3'd7) return h - p;
`endif
    return p;
  endfunction

  // Per-instance timeline model: ph 0 idle, 1 working, 2 result presented
  typedef struct packed {
    logic [1:0]  ph;
    int          cnt;
    logic [63:0] res;
    logic [63:0] pend;
    logic        d0;
    logic        pend_d0;
  } mdl_t;

  mdl_t m1, m4;

  function automatic mdl_t mdl_step(input mdl_t m, input int n);
    if (annul) begin
      m.ph = 2'd0;
      m.d0 = 1'b0;
    end else begin
      case (m.ph)
        2'd0: if (start) begin
          m.pend    = ref_result(op, op1, op2, hilo);
          m.pend_d0 = (op == 3'd2 || op == 3'd3) && (op2 == 32'd0);
          m.cnt     = m.pend_d0 ? 1 : n + 1;
          m.ph      = 2'd1;
        end
        2'd1: begin
          m.cnt--;
          if (m.cnt == 0) begin
            m.ph  = 2'd2;
            m.res = m.pend;
            m.d0  = m.pend_d0;
          end
        end
        default: if (!start) begin
          m.ph = 2'd0;
          m.d0 = 1'b0;
        end
      endcase
    end
    return m;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m1 = '0;
      m4 = '0;
    end else begin
      m1 = mdl_step(m1, W);
      m4 = mdl_step(m4, W / 4);
    end
  end

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("cyc_ready_u1", bus1.ready_o, m1.ph == 2'd2);
      chk("cyc_busy_u1", bus1.busy_o, m1.ph == 2'd1);
      chk("cyc_div0_u1", bus1.div0_o, m1.d0);
      chk("cyc_result_u1", bus1.result_o, m1.res);
      chk("cyc_ready_u4", bus4.ready_o, m4.ph == 2'd2);
      chk("cyc_busy_u4", bus4.busy_o, m4.ph == 2'd1);
      chk("cyc_div0_u4", bus4.div0_o, m4.d0);
      chk("cyc_result_u4", bus4.result_o, m4.res);
    end
  end

  // Issue at the current negedge, watch both instances complete, then release start
  task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] h, input logic [63:0] exp,
                       input logic exp_d0, input int lat1, input int lat4, input int hold);
    int c0, e1, e4, ed;
    op = o; op1 = a; op2 = b; hilo = h; start = 1'b1;
    c0 = cyc; e1 = -1; e4 = -1;
    for (int k = 0; k < 100 && e1 < 0; k++) begin
      @(negedge clk);
      ed = cyc - c0 - 1;
      if (ed == 0) begin
        op = ~o; op1 = ~a; op2 = ~b; hilo = ~h;
      end
      if (bus4.ready_o && e4 < 0) e4 = ed;
      if (bus1.ready_o && e1 < 0) e1 = ed;
      if (lat1 > 1 && (ed == 1 || ed == lat1 - 1)) chk({nm, "_busy_mid"}, bus1.busy_o, 1'b1);
    end
    chk({nm, "_lat_u1"}, 64'(e1), 64'(lat1));
    chk({nm, "_lat_u4"}, 64'(e4), 64'(lat4));
    chk({nm, "_res_u1"}, bus1.result_o, exp);
    chk({nm, "_res_u4"}, bus4.result_o, exp);
    chk({nm, "_div0"}, bus1.div0_o, exp_d0);
    chk({nm, "_busy_end"}, bus1.busy_o, 1'b0);
    repeat (hold) @(negedge clk);
    if (hold > 0) chk({nm, "_held_ready"}, {bus1.ready_o, bus4.ready_o}, 2'b11);
    start = 1'b0;
    @(negedge clk);
    chk({nm, "_ready_drop"}, {bus1.ready_o, bus4.ready_o}, 2'b00);
    chk({nm, "_div0_drop"}, {bus1.div0_o, bus4.div0_o}, 2'b00);
  endtask

  logic [63:0] prev1;

  initial begin
    rst = 1'b1; start = 1'b0; annul = 1'b0;
    op = 3'd0; op1 = '0; op2 = '0; hilo = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_result", {bus1.result_o, bus4.result_o}, 128'd0);
    chk("reset_flags", {bus1.ready_o, bus1.busy_o, bus1.div0_o,
                        bus4.ready_o, bus4.busy_o, bus4.div0_o}, 6'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'h3, 64'd0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 33, 9, 0);
    do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 64'd0, 64'h0000_0002_0000_000E, 1'b0, 33, 9, 0);
    do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 33, 9, 0);
    do_op("div_minneg", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 64'h0000_0000_8000_0000, 1'b0, 33, 9, 0);
    do_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 64'd0, 64'h0000_0005_FFFF_FFFF, 1'b1, 1, 1, 0);
    do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001, 1'b0, 33, 9, 3);
    do_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 64'd0, 64'h0000_0001_FFFF_FFFD, 1'b0, 33, 9, 0);
`ifdef MULDIV_ACC_EN
    do_op("madd", OP_MADD, 32'd2, 32'd3, 64'd1, 64'd7, 1'b0, 33, 9, 0);
    do_op("msubu", OP_MSUBU, 32'd1, 32'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 33, 9, 0);
`else
    do_op("madd", OP_MADD, 32'd2, 32'd3, 64'd1, 64'd6, 1'b0, 33, 9, 0);
    do_op("msubu", OP_MSUBU, 32'd1, 32'd1, 64'd0, 64'd1, 1'b0, 33, 9, 0);
`endif

    // Annul a long multiply mid-flight; the faster instance is annulled while presenting
    prev1 = bus1.result_o;
    op = OP_MULT; op1 = 32'd5; op2 = 32'd7; hilo = '0; start = 1'b1;
    repeat (11) @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("annul_idle_u1", {bus1.ready_o, bus1.busy_o}, 2'b00);
    chk("annul_keep_u1", bus1.result_o, prev1);
    chk("annul_done_u4", {bus4.ready_o, bus4.result_o}, {1'b0, 64'd35});
    annul = 1'b0;
    do_op("divu_after_annul", OP_DIVU, 32'd9, 32'd3, 64'd0, 64'h0000_0000_0000_0003, 1'b0, 33, 9, 0);

    // Start and annul together in IDLE must not launch anything
    op = OP_MULTU; op1 = 32'd3; op2 = 32'd3; start = 1'b1; annul = 1'b1;
    repeat (2) @(negedge clk);
    chk("start_annul_idle", {bus1.busy_o, bus1.ready_o, bus4.busy_o, bus4.ready_o}, 4'b0000);
    start = 1'b0; annul = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
